// File: rtl/digit_entry_if.sv
// Bundle between the digit-entry front end and its environment: raw buttons,
// digit switches and the enter-phase enable in; the guess, its digit count
// and the ready flag out.
`timescale 1ns/1ps
interface digit_entry_if #(
   parameter int NUM_DIGITS = 4
);
   logic                    enable;
   logic [3:0]              sw;
   logic                    btnDigit;
   logic                    btnBack;
   logic                    btnSubmit;
   logic [4*NUM_DIGITS-1:0] userInput;
   logic [2:0]              digitCount;
   logic                    inputReady;

   // Environment side: drives buttons/switches/enable, observes the guess.
   modport master (
      output enable, sw, btnDigit, btnBack, btnSubmit,
      input  userInput, digitCount, inputReady
   );

   // Design side.
   modport slave (
      input  enable, sw, btnDigit, btnBack, btnSubmit,
      output userInput, digitCount, inputReady
   );
endinterface

// File: rtl/digit_entry.sv
// Digit entry front end. Each raw button is synchronized, debounced and
// turned into a single press pulse; the pulses drive a small FSM that
// shifts hex digits in, backspaces them out and locks the guess on submit.
`timescale 1ns/1ps

// Per-button conditioning: 2-flop synchronizer, hold-time debounce and a
// registered rising-edge detector producing a one-cycle press pulse.
module btn_cond #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic press
);
   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync;
   logic          deb;
   logic          deb_q;
   logic [CW-1:0] cnt;

   // Two flops in front of everything; the button is asynchronous to clk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync <= 2'b00;
      else     sync <= {sync[0], raw};
   end

   // Debounced level only follows the synced level after it has differed
   // for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         deb <= 1'b0;
         cnt <= '0;
      end else if (sync[1] != deb) begin
         if (cnt == CNT_LAST) begin
            deb <= sync[1];
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end else begin
         cnt <= '0;
      end
   end

   // One pulse per debounced rising edge; release and hold produce nothing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         deb_q <= 1'b0;
         press <= 1'b0;
      end else begin
         deb_q <= deb;
         press <= deb & ~deb_q;
      end
   end
endmodule

module digit_entry #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int NUM_DIGITS      = 4
) (
   input  logic         clk,
   input  logic         rst,
   digit_entry_if.slave bus
);
   localparam int W = 4 * NUM_DIGITS;
   localparam logic [2:0] FULL = 3'(NUM_DIGITS);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ENTRY = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   // Button order: [0] digit, [1] back, [2] submit.
   logic [2:0] raw_btn;
   logic [2:0] press;
   logic       ev_digit, ev_back, ev_submit;

   logic [1:0]   state;
   logic [W-1:0] user_input;
   logic [2:0]   digit_count;
   logic         input_ready;

   assign raw_btn = {bus.btnSubmit, bus.btnBack, bus.btnDigit};

   genvar g;
   generate
      for (g = 0; g < 3; g++) begin : g_btn
         btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
            .clk   (clk),
            .rst   (rst),
            .raw   (raw_btn[g]),
            .press (press[g])
         );
      end
   endgenerate

   assign ev_digit  = press[0];
   assign ev_back   = press[1];
   assign ev_submit = press[2];

   // Entry FSM. Enable low beats everything; among presses in one cycle only
   // the highest priority (submit > back > digit) is considered, even when
   // that one turns out to be ignored, so nothing is queued.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         user_input  <= '0;
         digit_count <= '0;
         input_ready <= 1'b0;
      end else if (!bus.enable) begin
         state       <= IDLE;
         user_input  <= '0;
         digit_count <= '0;
         input_ready <= 1'b0;
      end else begin
         case (state)
            IDLE: state <= ENTRY;
            ENTRY: begin
               if (ev_submit) begin
                  if (digit_count == FULL) begin
                     input_ready <= 1'b1;
                     state       <= DONE;
                  end
               end else if (ev_back) begin
                  if (digit_count != 3'd0) begin
                     user_input  <= {4'h0, user_input[W-1:4]};
                     digit_count <= digit_count - 3'd1;
                  end
               end else if (ev_digit) begin
                  if (digit_count != FULL) begin
                     user_input  <= {user_input[W-5:0], bus.sw};
                     digit_count <= digit_count + 3'd1;
                  end
               end
            end
            DONE: ;  // guess frozen until enable drops
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.userInput  = user_input;
   assign bus.digitCount = digit_count;
   assign bus.inputReady = input_ready;
endmodule

// File: tb/tb_digit_entry.sv
// Directed bench for digit_entry with a short debounce window.
`timescale 1ns/1ps
module tb_digit_entry;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   digit_entry_if #(.NUM_DIGITS(4)) bus ();
   digit_entry #(.DEBOUNCE_CYCLES(4), .NUM_DIGITS(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic chk_out(input string tag, input logic [15:0] ui,
                          input logic [2:0] dc, input logic rdy);
      chk({tag, ".ui"},  32'(bus.userInput),  32'(ui));
      chk({tag, ".cnt"}, 32'(bus.digitCount), 32'(dc));
      chk({tag, ".rdy"}, 32'(bus.inputReady), 32'(rdy));
   endtask

   // which: bit0 digit, bit1 back, bit2 submit. Called on a negedge;
   // returns on a negedge once the debounced release has settled.
   task automatic press(input logic [2:0] which, input logic [3:0] s, input int hold);
      bus.sw        = s;
      bus.btnDigit  = which[0];
      bus.btnBack   = which[1];
      bus.btnSubmit = which[2];
      repeat (hold) @(negedge clk);
      bus.btnDigit  = 1'b0;
      bus.btnBack   = 1'b0;
      bus.btnSubmit = 1'b0;
      repeat (12) @(negedge clk);
   endtask

   task automatic digit(input logic [3:0] s);
      press(3'b001, s, 10);
   endtask

   initial begin
      rst           = 1'b1;
      bus.enable    = 1'b0;
      bus.sw        = 4'h0;
      bus.btnDigit  = 1'b0;
      bus.btnBack   = 1'b0;
      bus.btnSubmit = 1'b0;
      #2;
      chk_out("reset", 16'h0000, 3'd0, 1'b0);
      #8 rst = 1'b0;
      @(negedge clk);
      bus.enable = 1'b1;
      repeat (3) @(negedge clk);
      chk_out("enabled", 16'h0000, 3'd0, 1'b0);

      // Two-cycle glitch is shorter than the debounce window.
      press(3'b001, 4'hA, 2);
      chk_out("glitch", 16'h0000, 3'd0, 1'b0);

      // Long hold gives exactly one append.
      press(3'b001, 4'hA, 20);
      chk_out("hold", 16'h000A, 3'd1, 1'b0);

      press(3'b010, 4'h0, 10);
      chk_out("back_to_empty", 16'h0000, 3'd0, 1'b0);
      press(3'b010, 4'h0, 10);
      chk_out("back_empty_ign", 16'h0000, 3'd0, 1'b0);

      digit(4'hF);
      digit(4'hF);
      chk_out("ff", 16'h00FF, 3'd2, 1'b0);
      digit(4'hF);
      digit(4'h4);
      chk_out("fff4", 16'hFFF4, 3'd4, 1'b0);
      digit(4'h1);
      chk_out("fifth_ign", 16'hFFF4, 3'd4, 1'b0);

      press(3'b010, 4'h1, 10);
      chk_out("back", 16'h0FFF, 3'd3, 1'b0);
      press(3'b100, 4'h1, 10);
      chk_out("submit_short", 16'h0FFF, 3'd3, 1'b0);
      digit(4'h4);
      chk_out("refill", 16'hFFF4, 3'd4, 1'b0);
      press(3'b100, 4'h4, 10);
      chk_out("submit", 16'hFFF4, 3'd4, 1'b1);
      repeat (5) @(negedge clk);
      chk_out("ready_held", 16'hFFF4, 3'd4, 1'b1);
      digit(4'h7);
      chk_out("done_digit", 16'hFFF4, 3'd4, 1'b1);
      press(3'b010, 4'h7, 10);
      chk_out("done_back", 16'hFFF4, 3'd4, 1'b1);

      // Enable drop clears on the next edge.
      bus.enable = 1'b0;
      @(negedge clk);
      chk_out("disable", 16'h0000, 3'd0, 1'b0);

      // Submit and back in the same cycle: submit wins.
      bus.enable = 1'b1;
      repeat (2) @(negedge clk);
      digit(4'h1);
      digit(4'h2);
      digit(4'h3);
      digit(4'h4);
      chk_out("1234", 16'h1234, 3'd4, 1'b0);
      press(3'b110, 4'h4, 10);
      chk_out("sub_vs_back", 16'h1234, 3'd4, 1'b1);

      // Async reset mid-entry.
      bus.enable = 1'b0;
      @(negedge clk);
      bus.enable = 1'b1;
      repeat (2) @(negedge clk);
      digit(4'h5);
      digit(4'h6);
      chk_out("56", 16'h0056, 3'd2, 1'b0);
      rst = 1'b1;
      #1;
      chk_out("async_rst", 16'h0000, 3'd0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk_out("post_rst", 16'h0000, 3'd0, 1'b0);
      digit(4'h9);
      chk_out("post_rst_digit", 16'h0009, 3'd1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/digit_entry.md
Name: digit_entry

Overview:
- Front end of the enter phase: turns raw button presses and the 4-bit digit switches into the 16-bit user guess (four hex nibbles) and a ready flag.
- Its outputs drive the answer checker's user-input operand and the display block's user-input and input-ready inputs.
- Per button: synchronizes and debounces the input, then edge-detects it.
- Builds the number by shift-in, supports backspace, and locks the value on submit.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive clk cycles a synchronized button level must hold before the debounced level changes.
- NUM_DIGITS, 4, digits required before submit is accepted; userInput width is 4*NUM_DIGITS.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- enable  in  1  high during enter phase; low clears entry (display phase)
- sw  in  4  hex digit value to enter
- btnDigit  in  1  raw button: append sw as next digit
- btnBack  in  1  raw button: delete last digit
- btnSubmit  in  1  raw button: submit the guess
- userInput  out  16  digits entered so far; most recent digit in [3:0]
- digitCount  out  3  number of digits entered (0..4)
- inputReady  out  1  level; high while a submitted guess is held

Behaviour:
- Reset (async, rst=1): userInput=16'h0000, digitCount=0, inputReady=0, state=IDLE, all synchronizer, debounce and edge registers cleared (debounced levels 0).
- Synchronizer: each button passes through two flops.
- Debounce: per button counter. If the synced level differs from the debounced level, the counter increments; otherwise it clears. When the count reaches DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level takes the synced level and the counter clears.
- Press event: one-cycle pulse on a rising edge of the debounced level. Holding a button produces exactly one event. Release produces none.
- Latency: raw edge to press-event pulse = 2 sync cycles + DEBOUNCE_CYCLES + 1 edge cycle. Press event to output update = next clk edge.
- Event priority within one cycle: enable low > submit > back > digit. Only the highest-priority event is acted on; the others are discarded, not queued.
- State machine:
  - IDLE: outputs held at reset values. enable=1 -> ENTRY.
  - ENTRY:
    - digit event with digitCount<NUM_DIGITS: userInput <= {userInput[11:0], sw}; digitCount++.
    - digit event with digitCount==NUM_DIGITS: ignored (no wrap, no overwrite).
    - back event with digitCount>0: userInput <= {4'h0, userInput[15:4]}; digitCount--.
    - back event with digitCount==0: ignored.
    - submit event with digitCount==NUM_DIGITS: inputReady<=1 -> DONE.
    - submit event with digitCount<NUM_DIGITS: ignored.
  - DONE: userInput, digitCount and inputReady=1 frozen. All digit, back and submit events are ignored.
  - Any state with enable=0 -> IDLE next cycle: userInput=0, digitCount=0, inputReady=0. Debounce state is kept.
- sw is sampled in the same cycle as the digit event. sw is not synchronized; it is treated as quasi-static.
- rst asserted mid-entry or in DONE: immediate clear, identical to power-up.

Test Plan:
- Run with DEBOUNCE_CYCLES=4. rst=1 for 10 ns, then rst=0, enable=1 -> userInput=0000, digitCount=0, inputReady=0. The FSM reaches ENTRY.
- Debounce:
  - Glitch btnDigit high for 2 cycles -> no digit accepted.
  - Hold btnDigit high 20 cycles with sw=4'hA -> exactly one append: userInput=000A, digitCount=1.
- Enter F, F, F, 4 -> userInput=FFF4, digitCount=4. A fifth digit press with sw=1 -> unchanged FFF4.
- From FFF4: press back -> 0FFF, count 3. Press submit -> ignored, inputReady=0. Press digit with sw=4 -> FFF4, count 4. Press submit -> inputReady=1 and stays high. Further digit and back presses -> no change.
- Press btnSubmit and btnBack in the same cycle with count=4 -> submit wins, inputReady=1, userInput unchanged.
- Drop enable in DONE -> next cycle userInput=0, count=0, inputReady=0. Assert rst mid-entry at count=2 -> outputs clear asynchronously, before the next clk edge.
